// File: rtl/ps2_pkg.sv
// Shared constants, register map and receive-state encoding
// for the PS/2 port bridge.
package ps2_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CUR  = 2'd2;
    localparam logic [1:0] REG_PREV = 2'd3;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    localparam int CTL_FLUSH = 0;
    localparam int CTL_CLEAR = 1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic logic odd_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Scan-code FIFO: power-of-two depth, push/pop/flush.
// A push in the same cycle as a flush survives the flush.
module ps2_rx_fifo
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop || flush);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[flush ? AW'(0) : wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? AW'(1) : AW'(0);
            count  <= do_push ? CW'(1) : CW'(0);
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ps2_port_bridge.sv
// PS/2 keyboard receiver with scan-code FIFO and port-mapped registers.
// Define PS2_PARITY_CHK_EN to reject frames failing odd parity.
module ps2_port_bridge
    import ps2_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] BASE_ID     = 8'h10,
    parameter int         FILTER_LEN  = 8,
    parameter int         TIMEOUT_CYC = 200000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       READ_STROBE,
    input  logic       WRITE_STROBE,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    output logic [7:0] IN_PORT,
    output logic       DATA_VALID,
    output logic [7:0] KEY_CUR,
    output logic [7:0] KEY_PREV,
    output logic       OVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] ID_DATA = BASE_ID + {6'b0, REG_DATA};
    localparam logic [7:0] ID_STAT = BASE_ID + {6'b0, REG_STAT};
    localparam logic [7:0] ID_CUR  = BASE_ID + {6'b0, REG_CUR};
    localparam logic [7:0] ID_PREV = BASE_ID + {6'b0, REG_PREV};

    logic [1:0]    c_sync;
    logic [1:0]    d_sync;
    logic          c_filt;
    logic [FW-1:0] flt_cnt;
    logic          flt_flip;
    logic          fall;
    logic          d_bit;

    rx_state_e     state_q;
    rx_state_e     state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_q;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          push;

    logic          f_full;
    logic          f_empty;
    logic [CW-1:0] f_count;
    logic [7:0]    f_rdata;
    logic          pop;
    logic          wr_hit;
    logic          flush;
    logic          clear;
    logic          ovf_set;
    logic          ovf_q;
    logic          perr;
    logic [1:0]    cnt_sat;
    logic [7:0]    status;
    logic [7:0]    rd_d;
    logic          brk;
    logic [7:0]    key_cur;
    logic [7:0]    key_prev;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
        end
    end

    // The filtered clock only flips after FILTER_LEN samples disagree with it.
    assign flt_flip = (c_sync[1] != c_filt)
                   && (flt_cnt == FW'(FILTER_LEN - 1));
    assign d_bit    = d_sync[1];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            c_filt  <= 1'b1;
            flt_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            fall <= flt_flip && c_filt;
            if (c_sync[1] == c_filt) begin
                flt_cnt <= '0;
            end else if (flt_flip) begin
                c_filt  <= c_sync[1];
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    assign timeout = (state_q != RX_IDLE) && !fall
                  && (to_cnt == TW'(TIMEOUT_CYC - 1));

`ifdef PS2_PARITY_CHK_EN
    logic perr_set;
    logic perr_q;
`endif

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
`ifdef PS2_PARITY_CHK_EN
        perr_set = 1'b0;
`endif
        unique case (state_q)
            RX_IDLE: begin
                if (fall && !d_bit)
                    state_d = RX_DATA;
            end
            RX_DATA: begin
                if (fall && bit_cnt == 3'd7)
                    state_d = RX_PARITY;
            end
            RX_PARITY: begin
                if (fall)
                    state_d = RX_STOP;
            end
            RX_STOP: begin
                if (fall) begin
                    state_d = RX_IDLE;
                    if (d_bit) begin
`ifdef PS2_PARITY_CHK_EN
                        if (odd_ok(shreg, par_q))
                            push = 1'b1;
                        else
                            perr_set = 1'b1;
`else
                        push = 1'b1;
`endif
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
        if (timeout)
            state_d = RX_IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RX_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RX_IDLE)
                bit_cnt <= '0;
            if (fall && state_q == RX_DATA) begin
                shreg   <= {d_bit, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (fall && state_q == RX_PARITY)
                par_q <= d_bit;
            if (state_q == RX_IDLE || fall || timeout)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TW'(1);
        end
    end

    assign wr_hit  = WRITE_STROBE && (PORT_ID == ID_DATA);
    assign flush   = wr_hit && OUT_PORT[CTL_FLUSH];
    assign clear   = wr_hit && OUT_PORT[CTL_CLEAR];
    assign pop     = READ_STROBE && (PORT_ID == ID_DATA) && !f_empty;
    assign ovf_set = push && f_full && !pop && !flush;

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (push),
        .wdata (shreg),
        .pop   (pop),
        .flush (flush),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            ovf_q <= 1'b0;
        else if (clear)
            ovf_q <= 1'b0;
        else if (ovf_set)
            ovf_q <= 1'b1;
    end

`ifdef PS2_PARITY_CHK_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            perr_q <= 1'b0;
        else if (clear)
            perr_q <= 1'b0;
        else if (perr_set)
            perr_q <= 1'b1;
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    // Key tracking sees every good byte, even one the FIFO drops.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            brk      <= 1'b0;
            key_cur  <= '0;
            key_prev <= '0;
        end else if (push) begin
            if (shreg == PS2_BRK) begin
                brk <= 1'b1;
            end else if (shreg != PS2_EXT) begin
                if (brk) begin
                    brk <= 1'b0;
                end else begin
                    key_prev <= key_cur;
                    key_cur  <= shreg;
                end
            end
        end
    end

    assign cnt_sat = (f_count >= CW'(3)) ? 2'd3 : f_count[1:0];
    assign status  = {2'b00, perr, ovf_q, f_full, f_empty, cnt_sat};

    always_comb begin
        rd_d = 8'h00;
        unique case (1'b1)
            (PORT_ID == ID_DATA): rd_d = f_empty ? 8'h00 : f_rdata;
            (PORT_ID == ID_STAT): rd_d = status;
            (PORT_ID == ID_CUR):  rd_d = key_cur;
            (PORT_ID == ID_PREV): rd_d = key_prev;
            default:              rd_d = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            IN_PORT <= '0;
        else
            IN_PORT <= rd_d;
    end

    assign DATA_VALID = !f_empty;
    assign KEY_CUR    = key_cur;
    assign KEY_PREV   = key_prev;
    assign OVERFLOW   = ovf_q;

`ifndef PS2_PARITY_CHK_EN
    logic unused_par;
    assign unused_par = par_q;
`endif
    logic unused_out;
    assign unused_out = ^OUT_PORT[7:2];

endmodule

// File: tb/tb_ps2_port_bridge.sv
// Scoreboard bench for ps2_port_bridge: frames feed an expected-byte
// queue and a key model; port reads pop and compare.
module tb_ps2_port_bridge;
    import ps2_pkg::*;

    localparam int         DEPTH = 8;
    localparam logic [7:0] BASE  = 8'h10;
    localparam int         FLT   = 8;
    localparam int         TMO   = 2000;
    localparam int         H     = 30;
`ifdef PS2_PARITY_CHK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       READ_STROBE = 1'b0;
    logic       WRITE_STROBE = 1'b0;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic [7:0] IN_PORT;
    logic       DATA_VALID;
    logic [7:0] KEY_CUR;
    logic [7:0] KEY_PREV;
    logic       OVERFLOW;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] sb[$];
    logic [7:0] m_cur = 8'h00;
    logic [7:0] m_prev = 8'h00;
    logic       m_brk = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_perr = 1'b0;

    always #5 CLK = ~CLK;

    ps2_port_bridge #(
        .FIFO_DEPTH  (DEPTH),
        .BASE_ID     (BASE),
        .FILTER_LEN  (FLT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .READ_STROBE  (READ_STROBE),
        .WRITE_STROBE (WRITE_STROBE),
        .PORT_ID      (PORT_ID),
        .OUT_PORT     (OUT_PORT),
        .IN_PORT      (IN_PORT),
        .DATA_VALID   (DATA_VALID),
        .KEY_CUR      (KEY_CUR),
        .KEY_PREV     (KEY_PREV),
        .OVERFLOW     (OVERFLOW)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %02h exp %02h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic ps2_bit(input logic b);
        ps2d = b;
        cycles(H);
        ps2c = 1'b0;
        cycles(H);
        ps2c = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (sb.size() < DEPTH)
            sb.push_back(b);
        else
            m_ovf = 1'b1;
        if (b == PS2_BRK) begin
            m_brk = 1'b1;
        end else if (b != PS2_EXT) begin
            if (m_brk) begin
                m_brk = 1'b0;
            end else begin
                m_prev = m_cur;
                m_cur  = b;
            end
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_cur  = 8'h00;
        m_prev = 8'h00;
        m_brk  = 1'b0;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic p;
        p = bad_par ? ^b : ~^b;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++)
            ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        cycles(H);
        if (bad_par && PCHK)
            m_perr = 1'b1;
        else
            model_byte(b);
    endtask

    task automatic read_port(input logic [7:0] id, output logic [7:0] got);
        PORT_ID = id;
        READ_STROBE = 1'b1;
        cycles(1);
        READ_STROBE = 1'b0;
        got = IN_PORT;
        cycles(1);
    endtask

    task automatic read_head(input string tag);
        logic [7:0] g;
        logic [7:0] e;
        read_port(BASE, g);
        e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        chk(tag, g, e);
    endtask

    task automatic read_status(input string tag);
        logic [7:0] g;
        logic [1:0] c;
        int n;
        n = sb.size();
        c = (n >= 3) ? 2'd3 : 2'(n);
        read_port(BASE + 8'd1, g);
        chk(tag, g, {2'b00, m_perr, m_ovf, n == DEPTH, n == 0, c});
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_cur"}, KEY_CUR, m_cur);
        chk({tag, "_prev"}, KEY_PREV, m_prev);
        chk({tag, "_dv"}, {7'b0, DATA_VALID}, {7'b0, sb.size() != 0});
        chk({tag, "_ovf"}, {7'b0, OVERFLOW}, {7'b0, m_ovf});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in"}, IN_PORT, 8'h00);
        chk({tag, "_dv"}, {7'b0, DATA_VALID}, 8'h00);
        chk({tag, "_cur"}, KEY_CUR, 8'h00);
        chk({tag, "_prev"}, KEY_PREV, 8'h00);
        chk({tag, "_ovf"}, {7'b0, OVERFLOW}, 8'h00);
    endtask

    task automatic write_ctl(input logic [7:0] v);
        PORT_ID = BASE;
        OUT_PORT = v;
        WRITE_STROBE = 1'b1;
        cycles(1);
        WRITE_STROBE = 1'b0;
        OUT_PORT = 8'h00;
        if (v[0])
            sb.delete();
        if (v[1]) begin
            m_ovf  = 1'b0;
            m_perr = 1'b0;
        end
        cycles(1);
    endtask

    initial begin
        logic [7:0] g;
        logic [7:0] seq [4];
        seq = '{8'h1C, 8'hF0, 8'h1C, 8'h32};

        cycles(3);
        check_reset("rst0");
        RST = 1'b1;
        cycles(5);

        send_frame(8'h1C, 1'b0);
        check_state("one");
        read_status("one_stat");
        read_head("one_head");
        read_status("one_empty");

        foreach (seq[i])
            send_frame(seq[i], 1'b0);
        check_state("seq");
        for (int i = 0; i < 4; i++)
            read_head("seq_head");
        read_status("seq_empty");

        for (int i = 0; i < 9; i++)
            send_frame(8'h40 + 8'(i), 1'b0);
        check_state("full");
        read_status("full_stat");
        for (int i = 0; i < 8; i++)
            read_head("full_head");
        read_head("empty_read");
        write_ctl(8'h02);
        check_state("ovf_clr");
        read_status("ovf_clr_stat");

        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++)
            ps2_bit(i[0]);
        cycles(TMO + 10);
        send_frame(8'h45, 1'b0);
        check_state("tmo");
        read_head("tmo_head");
        read_status("tmo_empty");

        send_frame(8'h1C, 1'b1);
        check_state("par");
        read_status("par_stat");
        read_head("par_head");
        write_ctl(8'h02);
        read_status("par_clr");

        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        check_state("ext");
        write_ctl(8'h01);
        check_state("flush");
        read_status("flush_stat");

        send_frame(8'h11, 1'b0);
        read_port(BASE + 8'd2, g);
        chk("pre_rst_cur", g, m_cur);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++)
            ps2_bit(1'b1);
        ps2d = 1'b0;
        cycles(H);
        ps2c = 1'b0;
        cycles(20);
        RST = 1'b0;
        cycles(2);
        check_reset("rst_mid");
        model_reset();
        ps2c = 1'b1;
        ps2d = 1'b1;
        cycles(5);
        RST = 1'b1;
        cycles(H);
        send_frame(8'h29, 1'b0);
        check_state("post_rst");
        read_head("post_rst_head");
        read_status("post_rst_empty");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
